// File: rtl/receptor_comando_valvula.sv
// -----------------------------------------------------------------------------
// receptor_comando_valvula
//
// Front end of the tank controller on the RX pin. It contains an 8N1 UART
// receiver and a decoder for the manual-valve commands. The decoder turns
// ASCII bytes into the manual-mode and manual-open levels that the valve
// logic uses. A failsafe timer drops manual mode when no valid command has
// arrived for TIMEOUT_CICLOS clocks.
//
// Parameters
//   CICLOS_BIT      clocks per serial bit (even, >= 4)
//   TIMEOUT_CICLOS  clocks without a valid command before manual mode expires
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous reset, active low
//   RX               in   serial line, idle high, asynchronous to clock
//   dado_recebido    out  [7:0] last correctly framed byte
//   pronto_rx        out  1-cycle pulse: dado_recebido was updated
//   erro_quadro      out  1-cycle pulse: the stop bit was sampled low
//   comando_invalido out  1-cycle pulse: the framed byte is not a command
//   manual           out  level: manual valve control is active
//   abrir_manual     out  level: manual open request (always 0 when manual=0)
//   db_estado        out  [3:0] receiver state code
// -----------------------------------------------------------------------------
module receptor_comando_valvula #(
    parameter int CICLOS_BIT     = 434,
    parameter int TIMEOUT_CICLOS = 500_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] dado_recebido,
    output logic       pronto_rx,
    output logic       erro_quadro,
    output logic       comando_invalido,
    output logic       manual,
    output logic       abrir_manual,
    output logic [3:0] db_estado
);

    localparam int CNT_W = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam int TMO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [CNT_W-1:0] META_BIT = CNT_W'(CICLOS_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CICLOS_BIT - 1);
    localparam logic [TMO_W-1:0] FIM_TMO  = TMO_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        INICIO       = 4'd1,
        DADOS        = 4'd2,
        PARADA       = 4'd3,
        ESPERA_LINHA = 4'd5
    } estado_t;

    typedef enum logic [2:0] {
        CMD_MANUAL = 3'd0,
        CMD_ABRIR  = 3'd1,
        CMD_FECHAR = 3'd2,
        CMD_AUTO   = 3'd3,
        CMD_NENHUM = 3'd4
    } cmd_t;

    // Map a received byte to a command. Upper and lower case are accepted.
    function automatic cmd_t classifica(input logic [7:0] b);
        cmd_t c;
        case (b)
            8'h4D, 8'h6D: c = CMD_MANUAL;
            8'h41, 8'h61: c = CMD_ABRIR;
            8'h46, 8'h66: c = CMD_FECHAR;
            8'h55, 8'h75: c = CMD_AUTO;
            default:      c = CMD_NENHUM;
        endcase
        return c;
    endfunction

    // Synchronizer and line-valid tracking
    logic       rx_meta_r;
    logic       rx_sync_r;
    logic [1:0] sync_cheio_r;

    // Receiver
    estado_t          estado_r, estado_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       shift_r, shift_n;
    logic [7:0]       dado_r, dado_n;
    logic             pronto_r, pronto_n;
    logic             erro_r, erro_n;

    // Decoder and failsafe timer
    cmd_t             cmd_s;
    logic             cmd_valido_s;
    logic             manual_r, manual_n;
    logic             abrir_r, abrir_n;
    logic             invalido_r, invalido_n;
    logic [TMO_W-1:0] tmo_r, tmo_n;

    // Two-flop synchronizer for RX. Both stages reset to idle-high. The
    // sync_cheio_r chain marks when both stages hold real line samples. This
    // stops the reset value of the synchronizer from looking like "line seen
    // high" while RX is still low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            sync_cheio_r <= 2'b00;
        end else begin
            rx_meta_r    <= RX;
            rx_sync_r    <= rx_meta_r;
            sync_cheio_r <= {sync_cheio_r[0], 1'b1};
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= ESPERA_LINHA;
            cnt_r    <= '0;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            dado_r   <= 8'h00;
            pronto_r <= 1'b0;
            erro_r   <= 1'b0;
        end else begin
            estado_r <= estado_n;
            cnt_r    <= cnt_n;
            bit_r    <= bit_n;
            shift_r  <= shift_n;
            dado_r   <= dado_n;
            pronto_r <= pronto_n;
            erro_r   <= erro_n;
        end
    end

    // Receiver next state. The start bit is sampled at its middle, and every
    // later bit is sampled one full bit period after the previous sample.
    always_comb begin
        estado_n = estado_r;
        cnt_n    = cnt_r;
        bit_n    = bit_r;
        shift_n  = shift_r;
        dado_n   = dado_r;
        pronto_n = 1'b0;
        erro_n   = 1'b0;
        case (estado_r)
            ESPERA_LINHA: begin
                cnt_n = '0;
                bit_n = 3'd0;
                if (rx_sync_r && sync_cheio_r[1]) begin
                    estado_n = OCIOSO;
                end else begin
                    estado_n = ESPERA_LINHA;
                end
            end
            OCIOSO: begin
                cnt_n = '0;
                bit_n = 3'd0;
                if (!rx_sync_r) begin
                    estado_n = INICIO;
                end else begin
                    estado_n = OCIOSO;
                end
            end
            INICIO: begin
                if (cnt_r == META_BIT) begin
                    cnt_n = '0;
                    bit_n = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    if (rx_sync_r) begin
                        estado_n = OCIOSO;
                    end else begin
                        estado_n = DADOS;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            DADOS: begin
                if (cnt_r == FIM_BIT) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync_r, shift_r[7:1]};
                    bit_n   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        estado_n = PARADA;
                    end else begin
                        estado_n = DADOS;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            PARADA: begin
                if (cnt_r == FIM_BIT) begin
                    cnt_n = '0;
                    if (rx_sync_r) begin
                        dado_n   = shift_r;
                        pronto_n = 1'b1;
                        estado_n = OCIOSO;
                    end else begin
                        // A break or framing fault: wait for the line to idle.
                        erro_n   = 1'b1;
                        estado_n = ESPERA_LINHA;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                estado_n = ESPERA_LINHA;
                cnt_n    = '0;
                bit_n    = 3'd0;
            end
        endcase
    end

    // Decoder and failsafe registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            manual_r   <= 1'b0;
            abrir_r    <= 1'b0;
            invalido_r <= 1'b0;
            tmo_r      <= '0;
        end else begin
            manual_r   <= manual_n;
            abrir_r    <= abrir_n;
            invalido_r <= invalido_n;
            tmo_r      <= tmo_n;
        end
    end

    // Command decode and failsafe timer. The decoder acts on the registered
    // byte in the same cycle that pronto_rx is high. A valid command takes
    // priority over a timer expiry that falls in the same cycle.
    always_comb begin
        cmd_s        = classifica(dado_r);
        cmd_valido_s = 1'b0;
        manual_n     = manual_r;
        abrir_n      = abrir_r;
        invalido_n   = 1'b0;
        tmo_n        = tmo_r;
        if (pronto_r) begin
            case (cmd_s)
                CMD_MANUAL: begin
                    manual_n     = 1'b1;
                    abrir_n      = 1'b0;
                    cmd_valido_s = 1'b1;
                end
                CMD_ABRIR: begin
                    // Accepted in automatic mode, but it has no effect there.
                    if (manual_r) begin
                        abrir_n = 1'b1;
                    end else begin
                        abrir_n = 1'b0;
                    end
                    cmd_valido_s = 1'b1;
                end
                CMD_FECHAR: begin
                    abrir_n      = 1'b0;
                    cmd_valido_s = 1'b1;
                end
                CMD_AUTO: begin
                    manual_n     = 1'b0;
                    abrir_n      = 1'b0;
                    cmd_valido_s = 1'b1;
                end
                default: begin
                    invalido_n = 1'b1;
                end
            endcase
        end else begin
            cmd_valido_s = 1'b0;
        end

        if (cmd_valido_s) begin
            tmo_n = '0;
        end else if (!manual_r) begin
            tmo_n = '0;
        end else if (tmo_r == FIM_TMO) begin
            manual_n = 1'b0;
            abrir_n  = 1'b0;
            tmo_n    = '0;
        end else begin
            tmo_n = tmo_r + TMO_W'(1);
        end
    end

    assign dado_recebido    = dado_r;
    assign pronto_rx        = pronto_r;
    assign erro_quadro      = erro_r;
    assign comando_invalido = invalido_r;
    assign manual           = manual_r;
    assign abrir_manual     = abrir_r;
    assign db_estado        = estado_r;

endmodule

// File: tb/tb_receptor_comando_valvula.sv
// -----------------------------------------------------------------------------
// Testbench for receptor_comando_valvula (CICLOS_BIT=8, TIMEOUT_CICLOS=1000).
// The stimulus process queues every frame it sends, together with its
// expected kind (good byte or framing error). A monitor process pops one
// entry for each pronto_rx or erro_quadro pulse. It also runs a command-level
// reference model for the manual, abrir_manual and comando_invalido outputs.
// -----------------------------------------------------------------------------
module tb_receptor_comando_valvula;

    localparam int CB  = 8;
    localparam int TMO = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       RX    = 1'b1;
    logic [7:0] dado_recebido;
    logic       pronto_rx;
    logic       erro_quadro;
    logic       comando_invalido;
    logic       manual;
    logic       abrir_manual;
    logic [3:0] db_estado;

    receptor_comando_valvula #(
        .CICLOS_BIT     (CB),
        .TIMEOUT_CICLOS (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .RX               (RX),
        .dado_recebido    (dado_recebido),
        .pronto_rx        (pronto_rx),
        .erro_quadro      (erro_quadro),
        .comando_invalido (comando_invalido),
        .manual           (manual),
        .abrir_manual     (abrir_manual),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       erro;
        logic [7:0] dado;
    } esp_t;

    esp_t fila[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    // ---------------- monitor + reference model ----------------
    initial begin
        logic       man_m, abr_m, inv_m, nm, na, ni, valido;
        logic [7:0] last_good, letra;
        longint     cyc, last_cmd;
        esp_t       e;
        man_m = 1'b0; abr_m = 1'b0; inv_m = 1'b0;
        last_good = 8'h00; cyc = 0; last_cmd = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                man_m = 1'b0; abr_m = 1'b0; inv_m = 1'b0; last_good = 8'h00;
                check("reset_saidas",
                      {dado_recebido, pronto_rx, erro_quadro, comando_invalido, manual, abrir_manual},
                      32'd0);
            end else begin
                check("manual", manual, man_m);
                check("abrir_manual", abrir_manual, abr_m);
                check("comando_invalido", comando_invalido, inv_m);
                nm = man_m; na = abr_m; ni = 1'b0; valido = 1'b0;
                if (pronto_rx || erro_quadro) begin
                    check("pulsos_exclusivos", pronto_rx & erro_quadro, 1'b0);
                    check("quadro_esperado", fila.size() != 0, 1'b1);
                end
                if (pronto_rx && fila.size() != 0) begin
                    e = fila.pop_front();
                    check("tipo_pronto", e.erro, 1'b0);
                    check("dado_recebido", dado_recebido, e.dado);
                    last_good = e.dado;
                    letra = e.dado | 8'h20;   // ASCII case fold
                    if (letra == 8'h6D && (e.dado == 8'h4D || e.dado == 8'h6D)) begin
                        nm = 1'b1; na = 1'b0; valido = 1'b1;
                    end else if (letra == 8'h61 && (e.dado == 8'h41 || e.dado == 8'h61)) begin
                        if (man_m) na = 1'b1;
                        valido = 1'b1;
                    end else if (letra == 8'h66 && (e.dado == 8'h46 || e.dado == 8'h66)) begin
                        na = 1'b0; valido = 1'b1;
                    end else if (letra == 8'h75 && (e.dado == 8'h55 || e.dado == 8'h75)) begin
                        nm = 1'b0; na = 1'b0; valido = 1'b1;
                    end else begin
                        ni = 1'b1;
                    end
                    if (valido) last_cmd = cyc;
                end else if (erro_quadro && fila.size() != 0) begin
                    e = fila.pop_front();
                    check("tipo_erro", e.erro, 1'b1);
                    check("dado_inalterado", dado_recebido, last_good);
                end
                // Manual mode lasts 1000 clocks after the last valid command.
                if (!valido && man_m && (cyc - last_cmd == longint'(TMO))) begin
                    nm = 1'b0; na = 1'b0;
                end
                man_m = nm; abr_m = na; inv_m = ni;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic espera_ciclos(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bit_serial(input logic v);
        RX = v;
        espera_ciclos(CB);
    endtask

    task automatic envia(input logic [7:0] b, input logic stop_ok);
        esp_t e;
        e.erro = !stop_ok;
        e.dado = b;
        fila.push_back(e);
        bit_serial(1'b0);
        for (int i = 0; i < 8; i++) bit_serial(b[i]);
        bit_serial(stop_ok);
    endtask

    task automatic ocioso(input int n);
        RX = 1'b1;
        espera_ciclos(n);
    endtask

    task automatic espera_estado(input string nome, input logic [3:0] alvo, input int limite);
        int k;
        k = 0;
        while (db_estado !== alvo && k < limite) begin
            espera_ciclos(1);
            k++;
        end
        check(nome, db_estado, alvo);
    endtask

    initial begin
        logic [7:0] b;
        int         r, gap;
        logic       ok;

        // 1: reset with the line idle
        reset = 1'b0;
        RX    = 1'b1;
        @(posedge clock);
        #1;
        espera_ciclos(3);
        check("reset_db_estado", db_estado, 4'd5);
        check("reset_manual", manual, 1'b0);
        check("reset_dado", dado_recebido, 8'h00);
        reset = 1'b1;
        espera_estado("pos_reset_ocioso", 4'd0, 3);
        ocioso(5);

        // 2: 'M' then 'A'
        envia(8'h4D, 1'b1);
        ocioso(10);
        check("t2_manual", manual, 1'b1);
        envia(8'h41, 1'b1);
        ocioso(20);
        check("t2_manual_a", manual, 1'b1);
        check("t2_abrir", abrir_manual, 1'b1);

        // 3: 'A' in automatic mode, then an invalid byte
        reset = 1'b0;
        espera_ciclos(2);
        reset = 1'b1;
        espera_ciclos(5);
        envia(8'h41, 1'b1);
        ocioso(20);
        check("t3_abrir", abrir_manual, 1'b0);
        envia(8'h58, 1'b1);
        ocioso(20);
        check("t3_manual", manual, 1'b0);

        // 4: framing error, the line stays low after the stop bit
        envia(8'h4D, 1'b0);
        espera_ciclos(16);
        check("t4_espera_linha", db_estado, 4'd5);
        check("t4_dado", dado_recebido, 8'h58);
        RX = 1'b1;
        espera_estado("t4_volta_ocioso", 4'd0, 6);
        ocioso(10);

        // 5: 2-clock glitch
        RX = 1'b0;
        espera_ciclos(2);
        RX = 1'b1;
        espera_estado("t5_inicio", 4'd1, 4);
        espera_estado("t5_volta_ocioso", 4'd0, 8);
        ocioso(10);

        // 6a: failsafe timeout
        envia(8'h4D, 1'b1);
        ocioso(10);
        envia(8'h41, 1'b1);
        ocioso(1100);
        check("t6a_manual", manual, 1'b0);
        check("t6a_abrir", abrir_manual, 1'b0);

        // 6b: reset in the middle of a frame
        envia(8'h6D, 1'b1);
        ocioso(10);
        envia(8'h61, 1'b1);
        ocioso(10);
        check("t6b_abrir_antes", abrir_manual, 1'b1);
        RX = 1'b0;
        espera_ciclos(CB);
        bit_serial(1'b1);
        bit_serial(1'b0);
        espera_ciclos(3);
        reset = 1'b0;
        #1;
        check("t6b_manual", manual, 1'b0);
        check("t6b_abrir", abrir_manual, 1'b0);
        check("t6b_db_estado", db_estado, 4'd5);
        espera_ciclos(4);
        reset = 1'b1;
        espera_ciclos(20);
        check("t6b_espera_linha", db_estado, 4'd5);
        RX = 1'b1;
        espera_estado("t6b_volta_ocioso", 4'd0, 6);
        ocioso(10);
        envia(8'h46, 1'b1);
        ocioso(20);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    b = 8'h4D;
                2, 3:    b = 8'h41;
                4:       b = 8'h46;
                5:       b = 8'h55;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (r <= 5 && $urandom_range(0, 1) == 1) b = b | 8'h20;
            ok  = ($urandom_range(0, 7) != 0);
            gap = ($urandom_range(0, 5) == 0) ? $urandom_range(900, 1100) : $urandom_range(6, 60);
            envia(b, ok);
            ocioso(gap);
        end

        ocioso(50);
        check("fila_vazia", fila.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
